// File: rtl/systolic_pkg.sv
// Purpose: shared types and helpers for the systolic FIR chain (FSM state, saturation).
// Latency: n/a (types and a combinational function only).
// Backpressure: n/a.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_e;

    // Working width for saturation; wide enough for any ACC_W/OUT_W this block is built with.
    localparam int SAT_W = 64;

    typedef struct packed {
        logic                    ovf;
        logic signed [SAT_W-1:0] val;
    } sat_t;

    // Clamp a sign-extended accumulator to a signed out_w-bit range; ovf reports a clamp.
    function automatic sat_t sat_clamp(input logic signed [SAT_W-1:0] acc,
                                       input int unsigned             out_w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sat_t                    r;
        hi    = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo    = -(64'sd1 <<< (out_w - 1));
        r.ovf = 1'b0;
        r.val = acc;
        if (acc > hi) begin
            r.ovf = 1'b1;
            r.val = hi;
        end else if (acc < lo) begin
            r.ovf = 1'b1;
            r.val = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/systolic_tap.sv
// Purpose: one weight-stationary PE: weight register, signed multiplier, partial-sum register.
// Latency: 1 cycle from acc_en_i to p_o.
// Backpressure: none locally; the top only pulses acc_en_i on an accepted sample.
//
// Ports: w_shift_i/w_in_i load the weight from the next tap (w_o feeds the previous one);
//        acc_en_i registers w*x_i + p_in_i into p_o; clr_i zeroes p_o and wins over acc_en_i.
module systolic_tap
    import systolic_pkg::*;
#(
    parameter int DW    = 8,
    parameter int ACC_W = 18
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    w_shift_i,
    input  logic signed [DW-1:0]    w_in_i,
    output logic signed [DW-1:0]    w_o,
    input  logic                    acc_en_i,
    input  logic                    clr_i,
    input  logic signed [DW-1:0]    x_i,
    input  logic signed [ACC_W-1:0] p_in_i,
    output logic signed [ACC_W-1:0] p_o
);

    logic signed [DW-1:0]    w_q;
    logic signed [ACC_W-1:0] p_q;
    logic signed [ACC_W-1:0] p_d;
    logic signed [2*DW-1:0]  prod;

    // Full-precision product, sign-extended; ACC_W leaves headroom for the whole chain.
    assign prod = w_q * x_i;
    assign p_d  = ACC_W'(prod) + p_in_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q <= '0;
            p_q <= '0;
        end else begin
            if (w_shift_i) begin
                w_q <= w_in_i;
            end
            if (clr_i) begin
                p_q <= '0;
            end else if (acc_en_i) begin
                p_q <= p_d;
            end
        end
    end

    assign w_o = w_q;
    assign p_o = p_q;

endmodule

// File: rtl/systolic_fir_chain.sv
// Purpose: NUM_PE-tap transposed-form FIR (y[n] = sum w[k]*x[n-k]) with run-time weight load.
// Latency: y[n] valid one cycle after x[n] is accepted; 1 sample/cycle.
// Backpressure: in_ready drops while an output beat is held (out_valid && !out_ready).
//
// Ports: clk/rst_n/ena; cfg_load, clear commands; w_valid/w_data weight beats;
//        in_valid/in_ready/in_data sample stream; out_valid/out_ready/out_data result stream;
//        sat_flag sticky saturation indicator; state_o FSM state.
module systolic_fir_chain
    import systolic_pkg::*;
#(
    parameter int NUM_PE = 4,
    parameter int DW     = 8,
    parameter int OUT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic                    cfg_load,
    input  logic                    clear,
    input  logic                    w_valid,
    input  logic signed [DW-1:0]    w_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [DW-1:0]    in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    sat_flag,
    output logic [1:0]              state_o
);

    localparam int ACC_W  = 2 * DW + $clog2(NUM_PE);
    localparam int WCNT_W = $clog2(NUM_PE);

    state_e              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic                out_valid_q, out_valid_d;
    logic                sat_q, sat_d;

    logic                accept;
    logic                load_start;
    logic                flush;
    logic                w_shift;

    // Weight chain flows from w_data down toward tap 0; partial sums flow the same way.
    logic signed [DW-1:0]    w_chain [0:NUM_PE];
    logic signed [ACC_W-1:0] p_chain [0:NUM_PE];

    logic signed [SAT_W-1:0] acc_ext;
    sat_t                    sat_res;
    logic                    unused_w0;
    logic                    unused_sat_hi;

    // ------------------------------------------------------------------
    // Handshake and command decode
    // ------------------------------------------------------------------
    assign in_ready   = ena && (state_q == RUN) && !clear && (!out_valid_q || out_ready);
    assign accept     = in_valid && in_ready;
    // A pending output beat must drain before a reload may begin.
    assign load_start = ena && cfg_load && (state_q != LOAD) && !out_valid_q;
    assign w_shift    = ena && (state_q == LOAD) && w_valid;
    // Both a reload and a clear wipe partial sums and the output beat; cfg_load taking
    // precedence is implicit because both paths flush identically.
    assign flush      = load_start || (ena && clear && (state_q != LOAD));

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        unique case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d = LOAD;
                    wcnt_d  = '0;
                end
            end
            LOAD: begin
                if (w_shift) begin
                    wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_q == WCNT_W'(NUM_PE - 1)) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (load_start) begin
                    state_d = LOAD;
                    wcnt_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                wcnt_d  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output stage: tap 0's register holds the unsaturated head sum, so the
    // saturated out_data is a pure function of registered state.
    // ------------------------------------------------------------------
    assign acc_ext = SAT_W'(p_chain[0]);
    assign sat_res = sat_clamp(acc_ext, OUT_W);

    always_comb begin
        out_valid_d = out_valid_q;
        sat_d       = sat_q;
        if (flush) begin
            out_valid_d = 1'b0;
            sat_d       = 1'b0;
        end else begin
            if (accept) begin
                out_valid_d = 1'b1;
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end
            // Latch the clamp of the beat currently on the output so the flag stays sticky.
            if (out_valid_q && sat_res.ovf) begin
                sat_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wcnt_q      <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
        end else if (ena) begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            out_valid_q <= out_valid_d;
            sat_q       <= sat_d;
        end
    end

    // ------------------------------------------------------------------
    // Tap chain
    // ------------------------------------------------------------------
    assign w_chain[NUM_PE] = w_data;
    assign p_chain[NUM_PE] = '0;

    for (genvar k = 0; k < NUM_PE; k++) begin : g_tap
        systolic_tap #(
            .DW    (DW),
            .ACC_W (ACC_W)
        ) u_tap (
            .clk       (clk),
            .rst_n     (rst_n),
            .w_shift_i (w_shift),
            .w_in_i    (w_chain[k+1]),
            .w_o       (w_chain[k]),
            .acc_en_i  (accept),
            .clr_i     (flush),
            .x_i       (in_data),
            .p_in_i    (p_chain[k+1]),
            .p_o       (p_chain[k])
        );
    end

    // Tap 0's weight has no downstream consumer; upper saturation bits are constant sign copies.
    assign unused_w0     = ^w_chain[0];
    assign unused_sat_hi = ^sat_res.val[SAT_W-1:OUT_W];

    assign out_valid = out_valid_q;
    assign out_data  = sat_res.val[OUT_W-1:0];
    // The clamp of the visible beat shows immediately; sat_q keeps it after the beat drains.
    assign sat_flag  = sat_q || (out_valid_q && sat_res.ovf);
    assign state_o   = state_q;

endmodule

// File: tb/tb_systolic_fir_chain.sv
// Purpose: directed self-checking bench for systolic_fir_chain (NUM_PE=4, DW=8, OUT_W=16).
// Latency: checks each output one cycle after the accepting edge.
// Backpressure: exercises out_ready low with in_valid held high.
module tb_systolic_fir_chain;

    logic               clk;
    logic               rst_n;
    logic               ena;
    logic               cfg_load;
    logic               clear;
    logic               w_valid;
    logic signed [7:0]  w_data;
    logic               in_valid;
    logic               in_ready;
    logic signed [7:0]  in_data;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_data;
    logic               sat_flag;
    logic [1:0]         state_o;

    int n_cmp = 0;
    int n_err = 0;

    systolic_fir_chain #(
        .NUM_PE (4),
        .DW     (8),
        .OUT_W  (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .cfg_load  (cfg_load),
        .clear     (clear),
        .w_valid   (w_valid),
        .w_data    (w_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sat_flag  (sat_flag),
        .state_o   (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Offer one sample, confirm it is accepted, and check the result one cycle later.
    task automatic push(input logic signed [7:0] x, input int y, input string tag);
        in_valid = 1'b1;
        in_data  = x;
        #1;
        chk({tag, " in_ready"}, 32'(in_ready), 1);
        tick();
        chk({tag, " out_data"}, 32'(out_data), y);
        chk({tag, " out_valid"}, 32'(out_valid), 1);
    endtask

    task automatic load4(input logic signed [7:0] a, input logic signed [7:0] b,
                         input logic signed [7:0] c, input logic signed [7:0] d);
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        chk("load state", 32'(state_o), 1);
        w_valid = 1'b1;
        w_data  = a; tick();
        w_data  = b; tick();
        w_data  = c; tick();
        w_data  = d; tick();
        w_valid = 1'b0;
        chk("run state", 32'(state_o), 2);
    endtask

    initial begin
        rst_n     = 1'b0;
        ena       = 1'b1;
        cfg_load  = 1'b0;
        clear     = 1'b0;
        w_valid   = 1'b0;
        w_data    = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst state", 32'(state_o), 0);
        chk("rst in_ready", 32'(in_ready), 0);
        chk("rst out_valid", 32'(out_valid), 0);
        chk("rst out_data", 32'(out_data), 0);
        chk("rst sat_flag", 32'(sat_flag), 0);
        rst_n = 1'b1;

        // IDLE never accepts
        in_valid = 1'b1;
        in_data  = 8'sd5;
        #1;
        chk("idle in_ready", 32'(in_ready), 0);
        tick();
        tick();
        chk("idle out_valid", 32'(out_valid), 0);
        chk("idle state", 32'(state_o), 0);
        in_valid = 1'b0;

        // Impulse response with weights 1,2,3,4; includes an ena-low freeze
        load4(8'sd1, 8'sd2, 8'sd3, 8'sd4);
        push(8'sd1, 1, "imp0");
        ena      = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'sd0;
        #1;
        chk("ena low in_ready", 32'(in_ready), 0);
        tick();
        chk("ena low out_data", 32'(out_data), 1);
        chk("ena low out_valid", 32'(out_valid), 1);
        ena = 1'b1;
        push(8'sd0, 2, "imp1");
        push(8'sd0, 3, "imp2");
        push(8'sd0, 4, "imp3");
        push(8'sd0, 0, "imp4");
        chk("imp state", 32'(state_o), 2);
        in_valid = 1'b0;
        tick();
        chk("imp drained", 32'(out_valid), 0);

        // Saturation: 127 * -128 accumulated over four taps
        load4(8'sd127, 8'sd127, 8'sd127, 8'sd127);
        push(-8'sd128, -16256, "sat0");
        chk("sat0 flag", 32'(sat_flag), 0);
        push(-8'sd128, -32512, "sat1");
        chk("sat1 flag", 32'(sat_flag), 0);
        push(-8'sd128, -32768, "sat2");
        chk("sat2 flag", 32'(sat_flag), 1);
        push(-8'sd128, -32768, "sat3");
        in_valid = 1'b0;
        tick();
        chk("sat drained", 32'(out_valid), 0);
        chk("sat sticky", 32'(sat_flag), 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("sat cleared", 32'(sat_flag), 0);

        // Backpressure: three stalled cycles, then the rest of the impulse response
        load4(8'sd1, 8'sd2, 8'sd3, 8'sd4);
        push(8'sd1, 1, "bp0");
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'sd0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp in_ready", 32'(in_ready), 0);
            tick();
            chk("bp out_data", 32'(out_data), 1);
            chk("bp out_valid", 32'(out_valid), 1);
        end
        out_ready = 1'b1;
        push(8'sd0, 2, "bp1");
        push(8'sd0, 3, "bp2");
        push(8'sd0, 4, "bp3");
        push(8'sd0, 0, "bp4");
        in_valid = 1'b0;
        tick();

        // clear drops partial sums of x=5 and blocks a same-cycle sample
        push(8'sd5, 5, "pre clr");
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'sd1;
        #1;
        chk("clr in_ready", 32'(in_ready), 0);
        tick();
        clear = 1'b0;
        chk("clr out_valid", 32'(out_valid), 0);
        push(8'sd1, 1, "post clr0");
        push(8'sd0, 2, "post clr1");
        push(8'sd0, 3, "post clr2");
        push(8'sd0, 4, "post clr3");
        in_valid = 1'b0;
        tick();

        // Reset in the middle of a load, then a full reload from IDLE
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        w_valid  = 1'b1;
        w_data   = 8'sd9;
        tick();
        tick();
        w_valid = 1'b0;
        chk("midload state", 32'(state_o), 1);
        rst_n = 1'b0;
        #1;
        chk("midreset state", 32'(state_o), 0);
        chk("midreset out_data", 32'(out_data), 0);
        tick();
        rst_n = 1'b1;
        load4(8'sd2, 8'sd0, 8'sd0, 8'sd0);
        push(8'sd3, 6, "reload0");
        push(8'sd0, 0, "reload1");
        in_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
